// File: rtl/coin_button_conditioner.sv
// Input stage for the vending controller: synchronises and debounces five buttons,
// turns clean presses into one-cycle events and arbitrates them into coin/cancel/confirm.
module coin_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_btn_raw,
    output logic [4:0] o_btn_level,
    output logic       o_coin_valid,
    output logic [6:0] o_coin_cents,
    output logic       o_cancel_pulse,
    output logic       o_confirm_pulse,
    output logic       o_conflict
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]            r_s1;
    logic [4:0]            r_s2;
    logic [4:0]            r_stable;
    logic [4:0]            r_prev;
    logic [4:0][CNT_W-1:0] r_cnt;
    logic                  r_pend;

    logic                  r_coin_valid;
    logic [6:0]            r_coin_cents;
    logic                  r_cancel_pulse;
    logic                  r_confirm_pulse;
    logic                  r_conflict;

    logic [4:0]            w_ev;
    logic [2:0]            w_coin_ev;
    logic                  w_cancel_ev;
    logic                  w_confirm_ev;
    logic                  w_cv;
    logic [6:0]            w_cents;
    logic                  w_cp;
    logic                  w_fp;
    logic                  w_cf;
    logic                  w_pend_nxt;

    // Two-flop synchroniser followed by a restart-on-bounce debounce counter per button.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            r_prev   <= '0;
            r_cnt    <= '0;
        end else begin
            r_s1   <= i_btn_raw;
            r_s2   <= r_s1;
            r_prev <= r_stable;
            for (int i = 0; i < 5; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_ev         = r_stable & ~r_prev;
    assign w_coin_ev    = w_ev[2:0];
    assign w_cancel_ev  = w_ev[3];
    assign w_confirm_ev = w_ev[4];

    // Cancel beats everything; a confirm arriving with a coin is deferred one cycle.
    always_comb begin
        w_cv       = 1'b0;
        w_cents    = 7'd0;
        w_cp       = 1'b0;
        w_fp       = 1'b0;
        w_cf       = 1'b0;
        w_pend_nxt = r_pend;
        if (w_cancel_ev) begin
            w_cp       = 1'b1;
            w_cf       = (|w_coin_ev) | w_confirm_ev | r_pend;
            w_pend_nxt = 1'b0;
        end else if (|w_coin_ev) begin
            w_cv = 1'b1;
            if (w_coin_ev[0])      w_cents = 7'd50;
            else if (w_coin_ev[1]) w_cents = 7'd25;
            else                   w_cents = 7'd10;
            w_cf = (w_coin_ev[0] & (w_coin_ev[1] | w_coin_ev[2])) |
                   (w_coin_ev[1] & w_coin_ev[2]);
            if (w_confirm_ev) w_pend_nxt = 1'b1;
        end else if (w_confirm_ev || r_pend) begin
            w_fp       = 1'b1;
            w_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend          <= 1'b0;
            r_coin_valid    <= 1'b0;
            r_coin_cents    <= 7'd0;
            r_cancel_pulse  <= 1'b0;
            r_confirm_pulse <= 1'b0;
            r_conflict      <= 1'b0;
        end else begin
            r_pend          <= w_pend_nxt;
            r_coin_valid    <= w_cv;
            r_coin_cents    <= w_cents;
            r_cancel_pulse  <= w_cp;
            r_confirm_pulse <= w_fp;
            r_conflict      <= w_cf;
        end
    end

    assign o_btn_level     = r_stable;
    assign o_coin_valid    = r_coin_valid;
    assign o_coin_cents    = r_coin_cents;
    assign o_cancel_pulse  = r_cancel_pulse;
    assign o_confirm_pulse = r_confirm_pulse;
    assign o_conflict      = r_conflict;

endmodule
